ifetch: RTL
===========

Name: ifetch

Overview:
- Instruction fetch unit; sits directly upstream of the instruction register.
- Reads instruction words from the memory bus at the fetch address, holds them in a small prefetch queue, and drives the IR data and load strobe (ir_d / ir_c).
- Consumes jump redirects from the control unit and raises a sticky no-memory alarm when memory does not answer.

Parameters:
- TIMEOUT, 16, number of cycles mreq may stay high without mok before the alarm is raised (legal range 2..255).
- RESET_IC, 16'h0000, fetch address loaded at reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  fetching enabled (CPU running).
- jump  in  1  redirect fetch to jaddr; flushes the pipeline.
- jaddr  in  [0:15]  jump target address.
- nb  in  [0:3]  current memory block number; captured per request.
- mreq  out  1  memory read request.
- maddr  out  [0:15]  request address.
- mnb  out  [0:3]  request block number.
- mok  in  1  memory acknowledge; mdata is valid when mok is sampled high.
- mdata  in  [0:15]  memory read data.
- ir_d  out  [0:15]  instruction word to the IR d input.
- ir_c  out  1  IR load strobe; IR captures ir_d at the edge ending a cycle with ir_c=1.
- ic  out  [0:15]  address of the word currently on ir_d.
- take  in  1  decoder has consumed the IR content.
- alarm  out  1  no-memory alarm; sticky.

Behaviour:
- Reset (rst_n=0, async):
  - mreq, ir_c, alarm = 0; ir_d, ic, maddr, mnb = 0.
  - fa (fetch address) = RESET_IC; queue empty; ir_full = 0; FSM = IDLE.
- All outputs are registered.
- FSM states: IDLE, REQ, HALT.
- IDLE -> REQ when start=1, jump=0, alarm=0 and the queue has a free slot, counted at the current edge without pre-crediting a same-edge dequeue.
  - On entering REQ: mreq<=1, maddr<=fa, mnb<=nb, timeout counter cleared.
  - maddr and mnb are held stable while mreq=1.
- REQ, on an edge with mok=1:
  - mdata is written to the queue tail with address fa; fa<=fa+1 (mod 2^16; 16'hFFFF wraps to 0); mreq<=0.
  - Next state is IDLE. Back-to-back requests therefore have a minimum of one idle cycle between them.
- REQ, mok=0: the counter increments. When the counter reaches TIMEOUT-1: mreq<=0, alarm<=1, go to HALT; no further requests are issued.
- HALT: left only via jump or reset.
- start=0 while in REQ: the outstanding request completes or times out normally; no new request is issued afterwards.
- IR delivery:
  - At an edge where queue non-empty, ir_full=0, ir_c=0 and jump=0: ir_c<=1, ir_d<=head word, ic<=head address, head is dequeued.
  - ir_c lasts exactly one cycle. At the edge ending it, ir_full<=1.
- take: an edge with take=1 and ir_full=1 clears ir_full. take is ignored while ir_full=0 or while ir_c=1.
- Latency:
  - mok sampled at edge E with IR empty -> ir_c high during the cycle after E+1 -> IR loads at E+2.
  - Next delivery after take at edge T: ir_c high at the earliest after T+1.
- jump (priority over everything except reset), at the edge:
  - fa<=jaddr; queue flushed; ir_c<=0; ir_full<=0; mreq<=0.
  - A reply arriving in the same cycle (mok=1) is discarded.
  - alarm<=0; FSM<=IDLE.
- Queue full: no request is issued; fetching resumes after a dequeue.
- ic is not updated while no delivery occurs.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Defined: queue depth 2. A new fetch may be issued while the IR is full and one word is queued.
- Undefined: queue depth 1. At most one word sits between memory and the IR, and fetch waits for dequeue.
- Every other rule is identical in both builds.

Test Plan:
- Reset with RESET_IC=16'h0100; start=1; memory acks after 3 cycles with mdata=16'hA5A5 -> maddr=16'h0100, mnb=nb; ir_c pulses once 2 edges after mok; ir_d=16'hA5A5; ic=16'h0100; next maddr=16'h0101.
- Never take; memory always acks in 1 cycle -> with IFETCH_PREFETCH_EN exactly 2 words fetched after the first IR load, without it exactly 1; mreq then stays 0.
- jump=1 with jaddr=16'hFFFF in the same cycle as mok for 16'h0200 -> 16'h0200 word discarded (no ir_c for it); next maddr=16'hFFFF; following maddr=16'h0000 (wrap).
- mok held 0, TIMEOUT=16 -> mreq drops and alarm=1 exactly 16 cycles after mreq rose; no further mreq; a subsequent jump clears alarm and fetching restarts at jaddr.
- rst_n asserted mid-request with mreq=1 and ir_full=1 -> mreq, ir_c, alarm drop immediately (asynchronously); after release the first maddr=RESET_IC.
- take pulsed while ir_c=1 -> ignored; ir_full stays 1 and no second ir_c occurs until take is applied after the load edge.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: memory read FSM, prefetch queue and IR delivery.
// Optional feature macro IFETCH_PREFETCH_EN selects a two-entry queue (default: one entry).
module ifetch #(
  parameter int          TIMEOUT  = 16,
  parameter logic [0:15] RESET_IC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        jump,
  input  logic [0:15] jaddr,
  input  logic [0:3]  nb,
  output logic        mreq,
  output logic [0:15] maddr,
  output logic [0:3]  mnb,
  input  logic        mok,
  input  logic [0:15] mdata,
  output logic [0:15] ir_d,
  output logic        ir_c,
  output logic [0:15] ic,
  input  logic        take,
  output logic        alarm
);

`ifdef IFETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

  typedef struct packed {
    logic [0:15] data;
    logic [0:15] addr;
  } entry_t;

  state_t      state;
  logic [0:15] fa;
  logic [7:0]  wait_cnt;
  logic [1:0]  q_cnt;
  entry_t      q_head;
`ifdef IFETCH_PREFETCH_EN
  entry_t      q_tail;
`endif
  logic        ir_full;

  logic        enq;
  logic        deq;
  logic        slot_free;
  entry_t      q_new;

  always_comb begin
    enq       = (state == REQ) && mok;
    deq       = (q_cnt != 2'd0) && !ir_full && !ir_c;
    // Free slot is judged on the current occupancy; a dequeue at this edge is not credited.
    slot_free = q_cnt < DEPTH;
    q_new     = '{data: mdata, addr: fa};
  end

  // NOTE: every register here is updated with <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fa       <= RESET_IC;
      wait_cnt <= '0;
      q_cnt    <= '0;
      q_head   <= '0;
`ifdef IFETCH_PREFETCH_EN
      q_tail   <= '0;
`endif
      ir_full  <= 1'b0;
      mreq     <= 1'b0;
      maddr    <= '0;
      mnb      <= '0;
      ir_d     <= '0;
      ir_c     <= 1'b0;
      ic       <= '0;
      alarm    <= 1'b0;
    end else if (jump) begin
      // Redirect wins over everything: any reply landing this cycle is dropped.
      fa      <= jaddr;
      q_cnt   <= '0;
      ir_c    <= 1'b0;
      ir_full <= 1'b0;
      mreq    <= 1'b0;
      alarm   <= 1'b0;
      state   <= IDLE;
    end else begin
      q_cnt <= q_cnt + {1'b0, enq} - {1'b0, deq};

`ifdef IFETCH_PREFETCH_EN
      if (deq)
        q_head <= (q_cnt == 2'd2) ? q_tail : q_new;
      else if (enq && q_cnt == 2'd0)
        q_head <= q_new;
      if (enq && !deq && q_cnt == 2'd1)
        q_tail <= q_new;
`else
      if (enq)
        q_head <= q_new;
`endif

      ir_c <= deq;
      if (deq) begin
        ir_d <= q_head.data;
        ic   <= q_head.addr;
      end

      if (ir_c)
        ir_full <= 1'b1;
      else if (take && ir_full)
        ir_full <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !alarm && slot_free) begin
            mreq     <= 1'b1;
            maddr    <= fa;
            mnb      <= nb;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mok) begin
            fa    <= fa + 16'd1;
            mreq  <= 1'b0;
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            mreq  <= 1'b0;
            alarm <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
